mem_wb_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Accepts one retired EX operation per handshake and performs its data-memory access over a req/ack port (load or store).
- Writes the ALU result or the loaded value back to the 8-entry register file.
- Stalls EX via ex_ready while a memory access or writeback is outstanding; detects misaligned accesses and memory timeouts.

---
 rtl/mem_wb_pkg.sv | 22 ++
 rtl/mem_wb_timeout.sv | 28 ++
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 tb/tb_mem_wb_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types and constants for the memory/writeback stage
package mem_wb_pkg;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_REG_AW         = 3;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Word accesses only: any set bit under this mask is a misaligned address.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB       = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_wb_timeout.sv
// rtl/mem_wb_timeout.sv - saturating clear/enable counter with terminal-count flag
module mem_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  // Stops at the terminal count so it can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and register writeback stage; optional bypass via MEM_WB_FWD_EN
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int REG_AW         = DEF_REG_AW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_dest_reg,
  input  logic              ex_w_enable,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_err,
  input  logic              err_clr,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_value
);

  state_t            state;
  logic [REG_AW-1:0] dest_q;
  logic              tmo_tc;
  logic              mem_op;
  logic              bad_op;

  assign ex_ready = (state == IDLE);
  assign mem_op   = ex_is_load | ex_is_store;
  assign bad_op   = is_misaligned(ex_mem_addr[1:0]) | (ex_is_load & ex_is_store);

  mem_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != MEM_WAIT),
    .en   ((state == MEM_WAIT) && !dm_ack),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_err  <= 1'b0;
      dest_q   <= '0;
    end else begin
      rf_we <= 1'b0;
      // Clear first so an error raised below in the same cycle wins.
      if (err_clr) mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (mem_op) begin
              if (bad_op) begin
                mem_err <= 1'b1;
              end else begin
                dm_req   <= 1'b1;
                dm_we    <= ex_is_store;
                dm_addr  <= ex_mem_addr;
                dm_wdata <= ex_is_store ? ex_store_data : '0;
                dest_q   <= ex_dest_reg;
                state    <= MEM_WAIT;
              end
            end else if (ex_w_enable) begin
              rf_we    <= 1'b1;
              rf_waddr <= ex_dest_reg;
              rf_wdata <= ex_result;
            end
          end
        end
        MEM_WAIT: begin
          // Ack is checked before the timeout so a last-cycle ack completes normally.
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
              rf_we    <= 1'b1;
              rf_waddr <= dest_q;
              rf_wdata <= dm_rdata;
              state    <= WB;
            end else begin
              state <= IDLE;
            end
          end else if (tmo_tc) begin
            dm_req  <= 1'b0;
            mem_err <= 1'b1;
            state   <= IDLE;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_WB_FWD_EN
  // rf_we is already high for the whole WB cycle, so it covers the load bypass too.
  assign fwd_valid = rf_we;
  assign fwd_reg   = rf_waddr;
  assign fwd_value = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_value = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [2:0]  ex_dest_reg;
  logic        ex_w_enable;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_err;
  logic        err_clr;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [31:0] fwd_value;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_result    (ex_result),
    .ex_dest_reg  (ex_dest_reg),
    .ex_w_enable  (ex_w_enable),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_mem_addr  (ex_mem_addr),
    .ex_store_data(ex_store_data),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mem_err      (mem_err),
    .err_clr      (err_clr),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_value    (fwd_value)
  );

  typedef struct {
    logic [31:0] result;
    logic [2:0]  dest;
    logic        wen;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] result, input logic [2:0] dest, input logic wen,
                      input logic ld, input logic st, input logic [31:0] addr,
                      input logic [31:0] sdata);
    ex_result = result; ex_dest_reg = dest; ex_w_enable = wen;
    ex_is_load = ld; ex_is_store = st; ex_mem_addr = addr; ex_store_data = sdata;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_w_enable = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_fwd(input string name, input logic [2:0] reg_exp, input logic [31:0] val_exp);
`ifdef MEM_WB_FWD_EN
    check({name, "_fwd_valid"}, 64'(fwd_valid), 64'd1);
    check({name, "_fwd_reg"},   64'(fwd_reg),   64'(reg_exp));
    check({name, "_fwd_value"}, 64'(fwd_value), 64'(val_exp));
`else
    check({name, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
    check({name, "_fwd_reg"},   64'(fwd_reg),   64'd0);
    check({name, "_fwd_value"}, 64'(fwd_value), 64'd0);
    if (reg_exp == 3'd7 && val_exp == 32'd0) $display("note: unused forward expectation");
`endif
  endtask

  initial begin
    int cnt;
    logic saw_we;

    vecs[0] = '{32'h0000_1234, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 3'd7, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0};
    vecs[2] = '{32'h0000_0055, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    vecs[3] = '{32'h0,         3'd1, 1'b1, 1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
    vecs[4] = '{32'h0,         3'd1, 1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b1};
    vecs[5] = '{32'h0,         3'd4, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1};

    rst_n = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_dest_reg = '0; ex_w_enable = 1'b0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_mem_addr = '0; ex_store_data = '0;
    dm_rdata = '0; dm_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();

    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_dm_req",   64'(dm_req),   64'd0);
    check("rst_dm_addr",  64'(dm_addr),  64'd0);
    check("rst_rf_we",    64'(rf_we),    64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_mem_err",  64'(mem_err),  64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      clear_err();
      send(vecs[i].result, vecs[i].dest, vecs[i].wen, vecs[i].ld, vecs[i].st, vecs[i].addr, 32'h0);
      check($sformatf("vec%0d_rf_we", i),    64'(rf_we),    64'(vecs[i].exp_we));
      check($sformatf("vec%0d_mem_err", i),  64'(mem_err),  64'(vecs[i].exp_err));
      check($sformatf("vec%0d_dm_req", i),   64'(dm_req),   64'd0);
      check($sformatf("vec%0d_ex_ready", i), 64'(ex_ready), 64'd1);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].dest));
        check($sformatf("vec%0d_rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].result));
      end
      tick();
      check($sformatf("vec%0d_we_pulse", i), 64'(rf_we), 64'd0);
    end

    // Back-to-back ALU accepts
    clear_err();
    send(32'hA5A5_0001, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b0_rf_wdata", 64'(rf_wdata), 64'hA5A5_0001);
    check("b2b0_ready",    64'(ex_ready), 64'd1);
    check_fwd("b2b0", 3'd1, 32'hA5A5_0001);
    send(32'h5A5A_0002, 3'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b1_rf_we",    64'(rf_we),    64'd1);
    check("b2b1_rf_waddr", 64'(rf_waddr), 64'd6);
    check("b2b1_rf_wdata", 64'(rf_wdata), 64'h5A5A_0002);

    // Load with ack on the third request cycle
    send(32'h0, 3'd5, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    check("ld_req_c1",   64'(dm_req),   64'd1);
    check("ld_we",       64'(dm_we),    64'd0);
    check("ld_addr",     64'(dm_addr),  64'h100);
    check("ld_wdata",    64'(dm_wdata), 64'd0);
    check("ld_ready_c1", 64'(ex_ready), 64'd0);
    tick();
    check("ld_req_c2",   64'(dm_req),   64'd1);
    check("ld_ready_c2", 64'(ex_ready), 64'd0);
    tick();
    check("ld_req_c3",   64'(dm_req),   64'd1);
    check("ld_rf_we_c3", 64'(rf_we),    64'd0);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0; dm_rdata = '0;
    check("ld_req_drop",  64'(dm_req),   64'd0);
    check("ld_rf_we",     64'(rf_we),    64'd1);
    check("ld_rf_waddr",  64'(rf_waddr), 64'd5);
    check("ld_rf_wdata",  64'(rf_wdata), 64'hDEAD_BEEF);
    check("ld_ready_wb",  64'(ex_ready), 64'd0);
    check_fwd("ld_wb", 3'd5, 32'hDEAD_BEEF);
    tick();
    check("ld_we_pulse",  64'(rf_we),    64'd0);
    check("ld_ready_end", 64'(ex_ready), 64'd1);

    // Store: held until ack, no writeback
    send(32'h0, 3'd2, 1'b0, 1'b0, 1'b1, 32'h204, 32'h0000_CAFE);
    check("st_req",   64'(dm_req),   64'd1);
    check("st_we",    64'(dm_we),    64'd1);
    check("st_addr",  64'(dm_addr),  64'h204);
    check("st_wdata", 64'(dm_wdata), 64'h0000_CAFE);
    tick();
    check("st_hold_req",   64'(dm_req),   64'd1);
    check("st_hold_wdata", 64'(dm_wdata), 64'h0000_CAFE);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("st_req_drop", 64'(dm_req),   64'd0);
    check("st_no_rf_we", 64'(rf_we),    64'd0);
    check("st_ready",    64'(ex_ready), 64'd1);
    check("st_no_err",   64'(mem_err),  64'd0);

    // Timeout: request must stay up for exactly 16 cycles
    send(32'h0, 3'd3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    cnt = 0; saw_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dm_req !== 1'b1) break;
      if (rf_we === 1'b1) saw_we = 1'b1;
      cnt++;
      tick();
    end
    check("tmo_req_cycles", 64'(cnt),      64'd16);
    check("tmo_mem_err",    64'(mem_err),  64'd1);
    check("tmo_ready",      64'(ex_ready), 64'd1);
    check("tmo_no_rf_we",   64'(saw_we | rf_we), 64'd0);

    // Ack on the terminal-count cycle completes normally
    clear_err();
    send(32'h0, 3'd4, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    repeat (15) tick();
    check("tc_req_still", 64'(dm_req), 64'd1);
    dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
    tick();
    dm_ack = 1'b0; dm_rdata = '0;
    check("tc_rf_we",    64'(rf_we),    64'd1);
    check("tc_rf_wdata", 64'(rf_wdata), 64'h0BAD_F00D);
    check("tc_no_err",   64'(mem_err),  64'd0);
    tick();

    // New error in the same cycle as err_clr keeps the flag set
    send(32'h0, 3'd1, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0);
    check("err_set", 64'(mem_err), 64'd1);
    err_clr = 1'b1;
    send(32'h0, 3'd1, 1'b0, 1'b0, 1'b1, 32'h106, 32'h0);
    err_clr = 1'b0;
    check("err_clr_collide", 64'(mem_err), 64'd1);
    clear_err();
    check("err_cleared", 64'(mem_err), 64'd0);

    // Reset during MEM_WAIT aborts the access
    send(32'h0, 3'd2, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    check("rmid_req", 64'(dm_req), 64'd1);
    rst_n = 1'b0;
    tick();
    check("rmid_dm_req",  64'(dm_req),   64'd0);
    check("rmid_dm_addr", 64'(dm_addr),  64'd0);
    check("rmid_ready",   64'(ex_ready), 64'd1);
    check("rmid_rf_we",   64'(rf_we),    64'd0);
    rst_n = 1'b1;
    tick();
    check("rmid_after_rf_we", 64'(rf_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
